// File: rtl/trdb_packet_sched.sv
// -----------------------------------------------------------------------------
// trdb_packet_sched
//
// Packet scheduler between the trace-debugger priority logic and the packet
// assembler. It holds up to two requests in order and offers them downstream
// under valid/ready flow control. It also pulses a branch-map flush when a
// request carrying branches is taken, and runs the periodic resync counter
// that tells the encoder to force a sync packet.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of queue and counters
//   trace_en_i             tracing enabled (0: no accepts, resync held at 0)
//   req_*                  request side (valid/ready, format, subformat, branches)
//   pkt_*                  downstream head entry (valid/ready, fields)
//   branch_map_flush_o     one-cycle pulse after a branch-carrying accept
//   resync_max_i           packets between forced syncs (0 disables)
//   resync_req_o           level request to emit F_SYNC/SF_START
//   pkt_count_o            packets handed downstream, wraps at 2^32
// -----------------------------------------------------------------------------

package trdb_pkg;

    typedef enum logic [1:0] {
        F_BRANCH_FULL = 2'h0,
        F_BRANCH_DIFF = 2'h1,
        F_ADDR_ONLY   = 2'h2,
        F_SYNC        = 2'h3
    } trdb_format_t;

    typedef enum logic [1:0] {
        SF_START     = 2'h0,
        SF_EXCEPTION = 2'h1,
        SF_CONTEXT   = 2'h2,
        SF_UNDEF     = 2'h3
    } trdb_subformat_t;

endpackage

module trdb_packet_sched
    import trdb_pkg::*;
#(
    parameter int RESYNC_W = 16,
    parameter int BRANCH_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                trace_en_i,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  trdb_format_t        req_format_i,
    input  trdb_subformat_t     req_subformat_i,
    input  logic [BRANCH_W-1:0] req_branches_i,

    output logic                pkt_valid_o,
    input  logic                pkt_ready_i,
    output trdb_format_t        pkt_format_o,
    output trdb_subformat_t     pkt_subformat_o,
    output logic [BRANCH_W-1:0] pkt_branches_o,

    output logic                branch_map_flush_o,

    input  logic [RESYNC_W-1:0] resync_max_i,
    output logic                resync_req_o,

    output logic [31:0]         pkt_count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;

    // Head entry drives pkt_* directly; tail entry is only used in TWO.
    trdb_format_t        head_fmt_q, head_fmt_d;
    trdb_subformat_t     head_sub_q, head_sub_d;
    logic [BRANCH_W-1:0] head_br_q,  head_br_d;
    trdb_format_t        tail_fmt_q, tail_fmt_d;
    trdb_subformat_t     tail_sub_q, tail_sub_d;
    logic [BRANCH_W-1:0] tail_br_q,  tail_br_d;

    logic                flush_q, flush_d;
    logic [RESYNC_W-1:0] rs_cnt_q, rs_cnt_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d;

    logic                accept;
    logic                pop;

    // req_ready_o is a register, so accept never sees a combinational path
    // from the downstream ready.
    assign accept = req_valid_i & ready_q & trace_en_i;
    assign pop    = (state_q != EMPTY) & pkt_ready_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        head_fmt_d = head_fmt_q;
        head_sub_d = head_sub_q;
        head_br_d  = head_br_q;
        tail_fmt_d = tail_fmt_q;
        tail_sub_d = tail_sub_q;
        tail_br_d  = tail_br_q;
        flush_d    = 1'b0;
        rs_cnt_d   = rs_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (clear_i) begin
            // Clear wins over everything: same-cycle accept and pop are dropped.
            state_d   = EMPTY;
            rs_cnt_d  = '0;
            pkt_cnt_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        head_fmt_d = req_format_i;
                        head_sub_d = req_subformat_i;
                        head_br_d  = req_branches_i;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        // Head leaves and the new request replaces it directly.
                        head_fmt_d = req_format_i;
                        head_sub_d = req_subformat_i;
                        head_br_d  = req_branches_i;
                    end else if (accept) begin
                        state_d    = TWO;
                        tail_fmt_d = req_format_i;
                        tail_sub_d = req_subformat_i;
                        tail_br_d  = req_branches_i;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // ready_q is low here, so only a pop can happen.
                    if (pop) begin
                        state_d    = ONE;
                        head_fmt_d = tail_fmt_q;
                        head_sub_d = tail_sub_q;
                        head_br_d  = tail_br_q;
                    end
                end
                default: state_d = EMPTY;
            endcase

            // Every format this block can carry clears the branch map, so only
            // a non-empty branch count matters. accept gates out X on req_*.
            flush_d = accept && (req_branches_i != '0);

            if (pop) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end

            if (!trace_en_i) begin
                rs_cnt_d = '0;
            end else if (accept) begin
                if (req_format_i == F_SYNC) begin
                    // Only a start sync restarts the interval; other sync
                    // subformats leave it alone.
                    if (req_subformat_i == SF_START) begin
                        rs_cnt_d = '0;
                    end
                end else if (rs_cnt_q >= resync_max_i) begin
                    // Saturate, also pulling the count down if the limit shrank.
                    rs_cnt_d = resync_max_i;
                end else begin
                    rs_cnt_d = rs_cnt_q + 1'b1;
                end
            end
        end

        ready_d = (state_d != TWO);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            ready_q    <= 1'b1;
            head_fmt_q <= F_ADDR_ONLY;
            head_sub_q <= SF_UNDEF;
            head_br_q  <= '0;
            tail_fmt_q <= F_ADDR_ONLY;
            tail_sub_q <= SF_UNDEF;
            tail_br_q  <= '0;
            flush_q    <= 1'b0;
            rs_cnt_q   <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            head_fmt_q <= head_fmt_d;
            head_sub_q <= head_sub_d;
            head_br_q  <= head_br_d;
            tail_fmt_q <= tail_fmt_d;
            tail_sub_q <= tail_sub_d;
            tail_br_q  <= tail_br_d;
            flush_q    <= flush_d;
            rs_cnt_q   <= rs_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready_o        = ready_q;
    assign pkt_valid_o        = (state_q != EMPTY);
    assign pkt_format_o       = head_fmt_q;
    assign pkt_subformat_o    = head_sub_q;
    assign pkt_branches_o     = head_br_q;
    assign branch_map_flush_o = flush_q;
    assign pkt_count_o        = pkt_cnt_q;
    // A zero limit disables resync even though the counter then sits at 0.
    assign resync_req_o       = (rs_cnt_q == resync_max_i) && (resync_max_i != '0);

endmodule

// File: tb/tb_trdb_packet_sched.sv
module tb_trdb_packet_sched;
    import trdb_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            clear_i;
    logic            trace_en_i;
    logic            req_valid_i;
    logic            req_ready_o;
    trdb_format_t    req_format_i;
    trdb_subformat_t req_subformat_i;
    logic [4:0]      req_branches_i;
    logic            pkt_valid_o;
    logic            pkt_ready_i;
    trdb_format_t    pkt_format_o;
    trdb_subformat_t pkt_subformat_o;
    logic [4:0]      pkt_branches_o;
    logic            branch_map_flush_o;
    logic [15:0]     resync_max_i;
    logic            resync_req_o;
    logic [31:0]     pkt_count_o;

    always #5 clk_i = ~clk_i;

    trdb_packet_sched #(.RESYNC_W(16), .BRANCH_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .trace_en_i(trace_en_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_format_i(req_format_i), .req_subformat_i(req_subformat_i),
        .req_branches_i(req_branches_i),
        .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
        .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
        .pkt_branches_o(pkt_branches_o),
        .branch_map_flush_o(branch_map_flush_o),
        .resync_max_i(resync_max_i), .resync_req_o(resync_req_o),
        .pkt_count_o(pkt_count_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: an ordered list of pending packets plus counters.
    typedef struct {
        trdb_format_t    f;
        trdb_subformat_t s;
        logic [4:0]      b;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_cnt;
    int          m_rs;
    bit          m_flush;

    function automatic bit exp_rs_req();
        return (resync_max_i != 0) && (m_rs == int'(resync_max_i));
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_cnt   = 0;
        m_rs    = 0;
        m_flush = 0;
    endfunction

    // One clock: evaluate the handshake from the model's occupancy, advance
    // the model after the edge, then step 1 time unit past the edge.
    task automatic tick();
        bit   acc, pp;
        ent_t e;
        acc = (req_valid_i === 1'b1) && (m_q.size() < 2) && (trace_en_i === 1'b1);
        pp  = (m_q.size() > 0) && (pkt_ready_i === 1'b1);
        @(posedge clk_i);
        if (clear_i) begin
            m_q.delete();
            m_cnt   = 0;
            m_rs    = 0;
            m_flush = 0;
        end else begin
            m_flush = acc && (req_branches_i != 0);
            if (pp) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (acc) begin
                e.f = req_format_i;
                e.s = req_subformat_i;
                e.b = req_branches_i;
                m_q.push_back(e);
            end
            if (!trace_en_i) m_rs = 0;
            else if (acc) begin
                if (req_format_i == F_SYNC) begin
                    if (req_subformat_i == SF_START) m_rs = 0;
                end else begin
                    m_rs = (m_rs + 1 > int'(resync_max_i)) ? int'(resync_max_i) : m_rs + 1;
                end
            end
        end
        #1;
    endtask

    task automatic set_req(input bit v, input trdb_format_t f, input trdb_subformat_t s,
                           input logic [4:0] b);
        req_valid_i     = v;
        req_format_i    = f;
        req_subformat_i = s;
        req_branches_i  = b;
    endtask

    task automatic test_reset();
        n_chk++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", req_ready_o); end
        n_chk++; if (pkt_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", pkt_valid_o); end
        n_chk++; if (pkt_format_o !== F_ADDR_ONLY) begin n_fail++; $display("FAIL reset_format: got %0d want %0d", pkt_format_o, F_ADDR_ONLY); end
        n_chk++; if (pkt_subformat_o !== SF_UNDEF) begin n_fail++; $display("FAIL reset_subformat: got %0d want %0d", pkt_subformat_o, SF_UNDEF); end
        n_chk++; if (pkt_branches_o !== 5'd0) begin n_fail++; $display("FAIL reset_branches: got %0d want 0", pkt_branches_o); end
        n_chk++; if (pkt_count_o !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", pkt_count_o); end
        n_chk++; if (branch_map_flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b want 0", branch_map_flush_o); end
        n_chk++; if (resync_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_resync: got %0b want 0", resync_req_o); end
    endtask

    task automatic test_single();
        pkt_ready_i = 1'b1;
        set_req(1'b1, F_SYNC, SF_START, 5'd0);
        tick();
        set_req(1'b0, F_ADDR_ONLY, SF_UNDEF, 5'd0);
        n_chk++; if (pkt_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", pkt_valid_o); end
        n_chk++; if (pkt_format_o !== F_SYNC || pkt_subformat_o !== SF_START)
            begin n_fail++; $display("FAIL single_fields: got %0d/%0d want %0d/%0d", pkt_format_o, pkt_subformat_o, F_SYNC, SF_START); end
        n_chk++; if (branch_map_flush_o !== 1'b0) begin n_fail++; $display("FAIL single_flush: got %0b want 0", branch_map_flush_o); end
        tick();
        n_chk++; if (pkt_count_o !== 32'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", pkt_count_o); end
        n_chk++; if (pkt_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b want 0", pkt_valid_o); end
    endtask

    task automatic test_backpressure();
        trdb_format_t obs[$];
        trdb_format_t want[3];
        logic [31:0]  start_cnt;
        bit           will_acc;
        want[0] = F_BRANCH_FULL; want[1] = F_ADDR_ONLY; want[2] = F_BRANCH_DIFF;
        start_cnt   = pkt_count_o;
        pkt_ready_i = 1'b0;
        set_req(1'b1, F_BRANCH_FULL, SF_UNDEF, 5'd31);
        tick();
        n_chk++; if (branch_map_flush_o !== 1'b1) begin n_fail++; $display("FAIL bp_flush_a: got %0b want 1", branch_map_flush_o); end
        set_req(1'b1, F_ADDR_ONLY, SF_EXCEPTION, 5'd3);
        tick();
        n_chk++; if (branch_map_flush_o !== 1'b1) begin n_fail++; $display("FAIL bp_flush_b: got %0b want 1", branch_map_flush_o); end
        n_chk++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %0b want 0", req_ready_o); end
        set_req(1'b1, F_BRANCH_DIFF, SF_CONTEXT, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (req_ready_o !== 1'b0 || branch_map_flush_o !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold: ready=%0b flush=%0b want 0/0", req_ready_o, branch_map_flush_o); end
            n_chk++; if (pkt_format_o !== F_BRANCH_FULL || pkt_branches_o !== 5'd31)
                begin n_fail++; $display("FAIL bp_stable: got %0d/%0d want %0d/31", pkt_format_o, pkt_branches_o, F_BRANCH_FULL); end
        end
        pkt_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (pkt_valid_o === 1'b1) obs.push_back(pkt_format_o);
            will_acc = (req_valid_i === 1'b1) && (req_ready_o === 1'b1);
            tick();
            if (will_acc) req_valid_i = 1'b0;
        end
        n_chk++; if (obs.size() != 3) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 3", obs.size()); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_chk++; if (obs[i] !== want[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, obs[i], want[i]); end
        end
        n_chk++; if (pkt_count_o !== start_cnt + 32'd3) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", pkt_count_o, start_cnt + 32'd3); end
    endtask

    task automatic test_resync();
        pkt_ready_i  = 1'b1;
        resync_max_i = 16'd4;
        set_req(1'b1, F_ADDR_ONLY, SF_UNDEF, 5'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (resync_req_o !== (i == 3)) begin n_fail++; $display("FAIL rs_count[%0d]: got %0b want %0b", i, resync_req_o, (i == 3)); end
        end
        set_req(1'b1, F_SYNC, SF_START, 5'd0);
        tick();
        n_chk++; if (resync_req_o !== 1'b0) begin n_fail++; $display("FAIL rs_sync_start: got %0b want 0", resync_req_o); end
        set_req(1'b1, F_ADDR_ONLY, SF_UNDEF, 5'd0);
        repeat (4) tick();
        set_req(1'b1, F_SYNC, SF_CONTEXT, 5'd0);
        tick();
        n_chk++; if (resync_req_o !== 1'b1) begin n_fail++; $display("FAIL rs_sync_other: got %0b want 1", resync_req_o); end
        set_req(1'b1, F_BRANCH_DIFF, SF_UNDEF, 5'd0);
        tick();
        n_chk++; if (resync_req_o !== 1'b1) begin n_fail++; $display("FAIL rs_saturate: got %0b want 1", resync_req_o); end
        resync_max_i = 16'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++; if (resync_req_o !== 1'b0) begin n_fail++; $display("FAIL rs_disabled[%0d]: got %0b want 0", i, resync_req_o); end
        end
        req_valid_i = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_accept_pop();
        pkt_ready_i = 1'b0;
        set_req(1'b1, F_BRANCH_FULL, SF_UNDEF, 5'd2);
        tick();
        pkt_ready_i = 1'b1;
        set_req(1'b1, F_SYNC, SF_EXCEPTION, 5'd9);
        tick();
        req_valid_i = 1'b0;
        n_chk++; if (pkt_valid_o !== 1'b1 || req_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL ap_occupancy: valid=%0b ready=%0b want 1/1", pkt_valid_o, req_ready_o); end
        n_chk++; if (pkt_format_o !== F_SYNC || pkt_subformat_o !== SF_EXCEPTION || pkt_branches_o !== 5'd9)
            begin n_fail++; $display("FAIL ap_new_head: got %0d/%0d/%0d want %0d/%0d/9", pkt_format_o, pkt_subformat_o, pkt_branches_o, F_SYNC, SF_EXCEPTION); end
        tick();
        n_chk++; if (pkt_valid_o !== 1'b0) begin n_fail++; $display("FAIL ap_single_left: got %0b want 0", pkt_valid_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 100; i++) begin
            if (i % 20 == 0) resync_max_i = 16'($urandom_range(0, 3));
            req_valid_i = 1'($urandom_range(0, 1));
            req_format_i = trdb_format_t'($urandom_range(0, 3));
            req_subformat_i = trdb_subformat_t'($urandom_range(0, 3));
            req_branches_i = req_valid_i ? 5'($urandom_range(0, 31)) : 5'bx;
            pkt_ready_i = ($urandom_range(0, 3) != 0);
            trace_en_i  = ($urandom_range(0, 9) != 0);
            clear_i     = ($urandom_range(0, 31) == 0);
            tick();
            n_chk++; if (pkt_valid_o !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, pkt_valid_o, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                n_chk++; if (pkt_format_o !== m_q[0].f || pkt_subformat_o !== m_q[0].s || pkt_branches_o !== m_q[0].b)
                    begin n_fail++; $display("FAIL rnd_head[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, pkt_format_o, pkt_subformat_o, pkt_branches_o, m_q[0].f, m_q[0].s, m_q[0].b); end
            end
            n_chk++; if (req_ready_o !== (m_q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, req_ready_o, m_q.size() < 2); end
            n_chk++; if (branch_map_flush_o !== m_flush) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", i, branch_map_flush_o, m_flush); end
            n_chk++; if (pkt_count_o !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, pkt_count_o, m_cnt); end
            n_chk++; if (resync_req_o !== exp_rs_req()) begin n_fail++; $display("FAIL rnd_resync[%0d]: got %0b want %0b", i, resync_req_o, exp_rs_req()); end
        end
        clear_i = 1'b0; trace_en_i = 1'b1; req_valid_i = 1'b0; pkt_ready_i = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_trace_en();
        pkt_ready_i  = 1'b0;
        resync_max_i = 16'd1;
        set_req(1'b1, F_BRANCH_DIFF, SF_UNDEF, 5'd1);
        tick();
        set_req(1'b1, F_ADDR_ONLY, SF_START, 5'd4);
        tick();
        n_chk++; if (resync_req_o !== 1'b1) begin n_fail++; $display("FAIL te_resync_before: got %0b want 1", resync_req_o); end
        trace_en_i  = 1'b0;
        pkt_ready_i = 1'b1;
        tick();
        n_chk++; if (pkt_valid_o !== 1'b1 || pkt_format_o !== F_ADDR_ONLY)
            begin n_fail++; $display("FAIL te_drain: valid=%0b fmt=%0d want 1/%0d", pkt_valid_o, pkt_format_o, F_ADDR_ONLY); end
        n_chk++; if (resync_req_o !== 1'b0) begin n_fail++; $display("FAIL te_resync_zero: got %0b want 0", resync_req_o); end
        tick();
        n_chk++; if (pkt_valid_o !== 1'b0 || branch_map_flush_o !== 1'b0)
            begin n_fail++; $display("FAIL te_no_accept: valid=%0b flush=%0b want 0/0", pkt_valid_o, branch_map_flush_o); end
        trace_en_i  = 1'b1;
        req_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        pkt_ready_i = 1'b0;
        set_req(1'b1, F_SYNC, SF_CONTEXT, 5'd6);
        tick();
        set_req(1'b1, F_BRANCH_FULL, SF_UNDEF, 5'd7);
        tick();
        req_valid_i = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        n_chk++; if (pkt_valid_o !== 1'b0 || req_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL ar_handshake: valid=%0b ready=%0b want 0/1", pkt_valid_o, req_ready_o); end
        n_chk++; if (pkt_format_o !== F_ADDR_ONLY || pkt_subformat_o !== SF_UNDEF || pkt_branches_o !== 5'd0)
            begin n_fail++; $display("FAIL ar_fields: got %0d/%0d/%0d want %0d/%0d/0", pkt_format_o, pkt_subformat_o, pkt_branches_o, F_ADDR_ONLY, SF_UNDEF); end
        n_chk++; if (pkt_count_o !== 32'd0 || branch_map_flush_o !== 1'b0)
            begin n_fail++; $display("FAIL ar_counters: count=%0d flush=%0b want 0/0", pkt_count_o, branch_map_flush_o); end
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        pkt_ready_i = 1'b1;
        set_req(1'b1, F_ADDR_ONLY, SF_CONTEXT, 5'd5);
        tick();
        req_valid_i = 1'b0;
        n_chk++; if (pkt_valid_o !== 1'b1 || pkt_format_o !== F_ADDR_ONLY || pkt_branches_o !== 5'd5)
            begin n_fail++; $display("FAIL ar_first_req: valid=%0b fmt=%0d br=%0d want 1/%0d/5", pkt_valid_o, pkt_format_o, pkt_branches_o, F_ADDR_ONLY); end
        n_chk++; if (branch_map_flush_o !== 1'b1) begin n_fail++; $display("FAIL ar_first_flush: got %0b want 1", branch_map_flush_o); end
        tick();
        n_chk++; if (pkt_count_o !== 32'd1) begin n_fail++; $display("FAIL ar_count: got %0d want 1", pkt_count_o); end
    endtask

    task automatic test_clear();
        pkt_ready_i  = 1'b0;
        resync_max_i = 16'd2;
        set_req(1'b1, F_BRANCH_FULL, SF_UNDEF, 5'd3);
        tick();
        set_req(1'b1, F_BRANCH_DIFF, SF_UNDEF, 5'd8);
        tick();
        n_chk++; if (req_ready_o !== 1'b0 || resync_req_o !== 1'b1)
            begin n_fail++; $display("FAIL clr_setup: ready=%0b resync=%0b want 0/1", req_ready_o, resync_req_o); end
        clear_i     = 1'b1;
        pkt_ready_i = 1'b1;
        set_req(1'b1, F_ADDR_ONLY, SF_UNDEF, 5'd7);
        tick();
        n_chk++; if (pkt_valid_o !== 1'b0 || req_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL clr_two_state: valid=%0b ready=%0b want 0/1", pkt_valid_o, req_ready_o); end
        n_chk++; if (pkt_count_o !== 32'd0 || branch_map_flush_o !== 1'b0 || resync_req_o !== 1'b0)
            begin n_fail++; $display("FAIL clr_two_cnt: count=%0d flush=%0b resync=%0b want 0/0/0", pkt_count_o, branch_map_flush_o, resync_req_o); end
        clear_i     = 1'b0;
        pkt_ready_i = 1'b0;
        set_req(1'b1, F_SYNC, SF_START, 5'd1);
        tick();
        clear_i = 1'b1;
        set_req(1'b1, F_BRANCH_FULL, SF_UNDEF, 5'd12);
        tick();
        clear_i     = 1'b0;
        req_valid_i = 1'b0;
        n_chk++; if (pkt_valid_o !== 1'b0 || branch_map_flush_o !== 1'b0)
            begin n_fail++; $display("FAIL clr_one_accept: valid=%0b flush=%0b want 0/0", pkt_valid_o, branch_map_flush_o); end
        tick();
        n_chk++; if (pkt_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_stays_empty: got %0b want 0", pkt_valid_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        trace_en_i   = 1'b1;
        pkt_ready_i  = 1'b0;
        resync_max_i = 16'd0;
        set_req(1'b0, F_ADDR_ONLY, SF_UNDEF, 5'd0);
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_resync();
        test_accept_pop();
        test_random();
        test_trace_en();
        test_async_reset();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
